// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants and types for the register-file write-back front end.
package rf_wb_arbiter_pkg;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam logic [AW-1:0] REG_ZERO = 5'd0;

  // Which source owns the write port this cycle
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_FIFO = 2'd2
  } wb_src_e;
endpackage

// File: rtl/rf_wb_arbiter_wb_fifo.sv
// In-order FIFO for long-latency results; count is registered so full/empty
// are clean flop outputs usable as a ready signal.
module wb_fifo #(
  parameter int W     = 37,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           count;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap by natural overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: ALU results vs buffered long-latency
// results, plus the per-register busy scoreboard used for RAW stalls.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int DW    = rf_wb_arbiter_pkg::DW,
  parameter int AW    = rf_wb_arbiter_pkg::AW,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_rd,
  input  logic [DW-1:0] alu_data,
  output logic          alu_hold,
  input  logic          iss_valid,
  input  logic [AW-1:0] iss_rd,
  input  logic          lu_valid,
  output logic          lu_ready,
  input  logic [AW-1:0] lu_rd,
  input  logic [DW-1:0] lu_data,
  output logic          wb_wen,
  output logic [AW-1:0] wb_waddr,
  output logic [DW-1:0] wb_wdata,
  input  logic [AW-1:0] q_r1,
  input  logic [AW-1:0] q_r2,
  output logic          q_busy1,
  output logic          q_busy2,
  output logic          haz_err
);
  localparam int NREG = 1 << AW;
  localparam logic [AW-1:0] RZ = AW'(REG_ZERO);

  logic            fifo_full, fifo_empty, push, pop;
  logic [AW-1:0]   head_rd;
  logic [DW-1:0]   head_data;
  wb_src_e         src;
  logic [AW-1:0]   sel_rd;
  logic [DW-1:0]   sel_data;
  logic [NREG-1:0] busy, busy_nxt;
  logic            haz_nxt;

  assign lu_ready = !fifo_full;
  assign push     = lu_valid && !fifo_full;
  assign pop      = (src == SRC_FIFO);

  wb_fifo #(.W(AW + DW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({lu_rd, lu_data}),
    .dout  ({head_rd, head_data}),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A full FIFO outranks the ALU so long results cannot starve behind it
  always_comb begin
    src      = SRC_NONE;
    alu_hold = 1'b0;
    if (alu_valid && fifo_full) begin
      src      = SRC_FIFO;
      alu_hold = 1'b1;
    end else if (alu_valid) begin
      src = SRC_ALU;
    end else if (!fifo_empty) begin
      src = SRC_FIFO;
    end
    sel_rd   = (src == SRC_ALU) ? alu_rd   : head_rd;
    sel_data = (src == SRC_ALU) ? alu_data : head_data;
  end

  // Set is applied after clear so a same-register set wins
  always_comb begin
    busy_nxt = busy;
    if (pop && head_rd != RZ) busy_nxt[head_rd] = 1'b0;
    if (iss_valid && iss_rd != RZ) busy_nxt[iss_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
    haz_nxt = (iss_valid && iss_rd != RZ && busy[iss_rd]) ||
              (src == SRC_ALU && alu_rd != RZ && busy[alu_rd]);
  end

  assign q_busy1 = (q_r1 != RZ) && busy[q_r1];
  assign q_busy2 = (q_r2 != RZ) && busy[q_r2];

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= '0;
      wb_wen   <= 1'b0;
      wb_waddr <= '0;
      wb_wdata <= '0;
      haz_err  <= 1'b0;
    end else begin
      busy    <= busy_nxt;
      haz_err <= haz_nxt;
      // $0 writes are consumed but never reach the register file
      if (src != SRC_NONE && sel_rd != RZ) begin
        wb_wen   <= 1'b1;
        wb_waddr <= sel_rd;
        wb_wdata <= sel_data;
      end else begin
        wb_wen <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_rf_wb_arbiter;
  logic        clk = 0;
  logic        rst = 1;
  logic        alu_valid = 0, iss_valid = 0, lu_valid = 0;
  logic [4:0]  alu_rd = 0, iss_rd = 0, lu_rd = 0, q_r1 = 0, q_r2 = 0;
  logic [31:0] alu_data = 0, lu_data = 0;
  logic        alu_hold, lu_ready, wb_wen, q_busy1, q_busy2, haz_err;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;

  int vectors = 0, miscompares = 0;

  rf_wb_arbiter #(.DW(32), .AW(5), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_hold(alu_hold),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
    .wb_wen(wb_wen), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .q_r1(q_r1), .q_r2(q_r2), .q_busy1(q_busy1), .q_busy2(q_busy2),
    .haz_err(haz_err)
  );

  always #5 clk = ~clk;

  // Reference model: result queue, busy bit per register, expected outputs
  typedef struct { logic [4:0] rd; logic [31:0] d; } ent_t;
  ent_t        mq[$];
  bit          mbusy[32];
  logic        m_wen, m_haz;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  // comb outputs seen mid-cycle, and what the model expected for them
  logic c_hold, c_ready, c_qb1, c_qb2, e_hold, e_ready, e_qb1, e_qb2;

  function automatic void m_write(input logic [4:0] rd, input logic [31:0] d);
    if (rd != 0) begin m_wen = 1; m_waddr = rd; m_wdata = d; end
    else m_wen = 0;
  endfunction

  task automatic apply(input logic rv, input logic av, input logic [4:0] ard,
                       input logic [31:0] ad, input logic iv, input logic [4:0] ird,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld);
    bit full;
    ent_t e;
    @(negedge clk);
    rst = rv; alu_valid = av; alu_rd = ard; alu_data = ad;
    iss_valid = iv; iss_rd = ird; lu_valid = lv; lu_rd = lrd; lu_data = ld;
    #1;
    c_hold = alu_hold; c_ready = lu_ready; c_qb1 = q_busy1; c_qb2 = q_busy2;
    full    = (mq.size() == 2);
    e_ready = !full;
    e_hold  = av && full;
    e_qb1   = (q_r1 != 0) && mbusy[q_r1];
    e_qb2   = (q_r2 != 0) && mbusy[q_r2];
    if (rv) begin
      mq.delete();
      foreach (mbusy[i]) mbusy[i] = 0;
      m_wen = 0; m_waddr = 0; m_wdata = 0; m_haz = 0;
    end else begin
      m_haz = iv && ird != 0 && mbusy[ird];
      if (av && !full) begin
        m_haz = m_haz || (ard != 0 && mbusy[ard]);
        m_write(ard, ad);
      end else if (mq.size() > 0) begin
        e = mq.pop_front();
        m_write(e.rd, e.d);
        if (e.rd != 0) mbusy[e.rd] = 0;
      end else m_wen = 0;
      if (iv && ird != 0) mbusy[ird] = 1;
      if (lv && !full) mq.push_back('{lrd, ld});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    apply(1, 1, 5, 32'h55, 1, 6, 1, 7, 32'h77);
    apply(1, 1, 5, 32'h55, 1, 6, 1, 7, 32'h77);
    vectors++; if (wb_wen !== 1'b0) begin miscompares++; $display("FAIL reset_wen: got %b want 0", wb_wen); end
    vectors++; if (wb_waddr !== 5'd0) begin miscompares++; $display("FAIL reset_waddr: got %0d want 0", wb_waddr); end
    vectors++; if (wb_wdata !== 32'd0) begin miscompares++; $display("FAIL reset_wdata: got %h want 0", wb_wdata); end
    vectors++; if (haz_err !== 1'b0) begin miscompares++; $display("FAIL reset_haz: got %b want 0", haz_err); end
    idle();
    vectors++; if (c_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", c_ready); end
    vectors++; if (c_hold !== 1'b0) begin miscompares++; $display("FAIL reset_hold: got %b want 0", c_hold); end
  endtask

  task automatic test_alu_basic();
    do_reset();
    apply(0, 1, 5, 32'h1234, 0, 0, 0, 0, 0);
    vectors++; if (wb_wen !== 1'b1) begin miscompares++; $display("FAIL alu_wen: got %b want 1", wb_wen); end
    vectors++; if (wb_waddr !== 5'd5) begin miscompares++; $display("FAIL alu_waddr: got %0d want 5", wb_waddr); end
    vectors++; if (wb_wdata !== 32'h1234) begin miscompares++; $display("FAIL alu_wdata: got %h want 1234", wb_wdata); end
    idle();
    vectors++; if (wb_wen !== 1'b0) begin miscompares++; $display("FAIL alu_idle_wen: got %b want 0", wb_wen); end
  endtask

  task automatic test_long_latency();
    do_reset();
    q_r1 = 7;
    apply(0, 0, 0, 0, 1, 7, 0, 0, 0);
    idle();
    vectors++; if (c_qb1 !== 1'b1) begin miscompares++; $display("FAIL long_busy_set: got %b want 1", c_qb1); end
    apply(0, 0, 0, 0, 0, 0, 1, 7, 32'hBEEF);
    vectors++; if (c_qb1 !== 1'b1) begin miscompares++; $display("FAIL long_busy_push: got %b want 1", c_qb1); end
    idle();
    vectors++; if (c_qb1 !== 1'b1) begin miscompares++; $display("FAIL long_busy_pop: got %b want 1", c_qb1); end
    vectors++; if (wb_wen !== 1'b1 || wb_waddr !== 5'd7 || wb_wdata !== 32'hBEEF) begin
      miscompares++; $display("FAIL long_wb: got %b/%0d/%h want 1/7/beef", wb_wen, wb_waddr, wb_wdata); end
    idle();
    vectors++; if (c_qb1 !== 1'b0) begin miscompares++; $display("FAIL long_busy_clr: got %b want 0", c_qb1); end
    q_r1 = 0;
  endtask

  task automatic test_full_hold();
    do_reset();
    apply(0, 1, 1, 32'h1, 0, 0, 1, 11, 32'hA);
    apply(0, 1, 2, 32'h2, 0, 0, 1, 12, 32'hB);
    apply(0, 1, 3, 32'hC, 0, 0, 1, 13, 32'hD);
    vectors++; if (c_hold !== 1'b1) begin miscompares++; $display("FAIL full_hold: got %b want 1", c_hold); end
    vectors++; if (c_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready: got %b want 0", c_ready); end
    vectors++; if (wb_waddr !== 5'd11 || wb_wdata !== 32'hA) begin
      miscompares++; $display("FAIL full_head: got %0d/%h want 11/a", wb_waddr, wb_wdata); end
    apply(0, 1, 3, 32'hC, 0, 0, 0, 0, 0);
    vectors++; if (c_hold !== 1'b0) begin miscompares++; $display("FAIL full_rehold: got %b want 0", c_hold); end
    vectors++; if (wb_waddr !== 5'd3 || wb_wdata !== 32'hC) begin
      miscompares++; $display("FAIL full_alu: got %0d/%h want 3/c", wb_waddr, wb_wdata); end
    idle();
    vectors++; if (wb_wen !== 1'b1 || wb_waddr !== 5'd12 || wb_wdata !== 32'hB) begin
      miscompares++; $display("FAIL full_second: got %b/%0d/%h want 1/12/b", wb_wen, wb_waddr, wb_wdata); end
    idle();
    vectors++; if (wb_wen !== 1'b0) begin miscompares++; $display("FAIL full_drain: got %b want 0", wb_wen); end
  endtask

  task automatic test_zero_reg();
    do_reset();
    q_r1 = 0; q_r2 = 0;
    apply(0, 1, 0, 32'hFFFF, 1, 0, 0, 0, 0);
    vectors++; if (wb_wen !== 1'b0) begin miscompares++; $display("FAIL zero_wen: got %b want 0", wb_wen); end
    idle();
    vectors++; if (c_qb1 !== 1'b0 || c_qb2 !== 1'b0) begin
      miscompares++; $display("FAIL zero_busy: got %b%b want 00", c_qb1, c_qb2); end
    vectors++; if (haz_err !== 1'b0) begin miscompares++; $display("FAIL zero_haz: got %b want 0", haz_err); end
  endtask

  task automatic test_waw();
    do_reset();
    q_r2 = 9;
    apply(0, 0, 0, 0, 1, 9, 0, 0, 0);
    vectors++; if (haz_err !== 1'b0) begin miscompares++; $display("FAIL waw_first: got %b want 0", haz_err); end
    apply(0, 0, 0, 0, 1, 9, 0, 0, 0);
    vectors++; if (haz_err !== 1'b1) begin miscompares++; $display("FAIL waw_pulse: got %b want 1", haz_err); end
    idle();
    vectors++; if (haz_err !== 1'b0) begin miscompares++; $display("FAIL waw_end: got %b want 0", haz_err); end
    vectors++; if (c_qb2 !== 1'b1) begin miscompares++; $display("FAIL waw_busy: got %b want 1", c_qb2); end
    q_r2 = 0;
  endtask

  task automatic test_reset_midop();
    do_reset();
    q_r1 = 20;
    apply(0, 1, 1, 32'h1, 1, 20, 1, 21, 32'h21);
    apply(0, 1, 2, 32'h2, 0, 0, 1, 22, 32'h22);
    apply(1, 1, 3, 32'h3, 0, 0, 0, 0, 0);
    vectors++; if (wb_wen !== 1'b0) begin miscompares++; $display("FAIL rmid_wen: got %b want 0", wb_wen); end
    idle();
    vectors++; if (c_ready !== 1'b1 || c_hold !== 1'b0) begin
      miscompares++; $display("FAIL rmid_flags: got ready=%b hold=%b want 1/0", c_ready, c_hold); end
    vectors++; if (c_qb1 !== 1'b0) begin miscompares++; $display("FAIL rmid_busy: got %b want 0", c_qb1); end
    vectors++; if (wb_wen !== 1'b0) begin miscompares++; $display("FAIL rmid_empty: got %b want 0", wb_wen); end
    q_r1 = 0;
  endtask

  task automatic test_random();
    logic av, iv, lv, held;
    logic [4:0] ard, ird, lrd;
    logic [31:0] ad, ld;
    do_reset();
    held = 0; av = 0; ard = 0; ad = 0;
    for (int n = 0; n < 400; n++) begin
      if (!held) begin
        av = ($urandom % 3) != 0; ard = 5'($urandom % 8); ad = $urandom;
      end
      iv = ($urandom % 4) == 0; ird = 5'($urandom % 8);
      lv = ($urandom % 2) == 0; lrd = 5'($urandom % 8); ld = $urandom;
      q_r1 = 5'($urandom % 8); q_r2 = 5'($urandom % 8);
      apply(0, av, ard, ad, iv, ird, lv, lrd, ld);
      held = c_hold;
      vectors++; if (c_hold !== e_hold) begin miscompares++; $display("FAIL rnd_hold @%0d: got %b want %b", n, c_hold, e_hold); end
      vectors++; if (c_ready !== e_ready) begin miscompares++; $display("FAIL rnd_ready @%0d: got %b want %b", n, c_ready, e_ready); end
      vectors++; if (c_qb1 !== e_qb1 || c_qb2 !== e_qb2) begin
        miscompares++; $display("FAIL rnd_qbusy @%0d: got %b%b want %b%b", n, c_qb1, c_qb2, e_qb1, e_qb2); end
      vectors++; if (wb_wen !== m_wen) begin miscompares++; $display("FAIL rnd_wen @%0d: got %b want %b", n, wb_wen, m_wen); end
      vectors++; if (wb_waddr !== m_waddr || wb_wdata !== m_wdata) begin
        miscompares++; $display("FAIL rnd_wb @%0d: got %0d/%h want %0d/%h", n, wb_waddr, wb_wdata, m_waddr, m_wdata); end
      vectors++; if (haz_err !== m_haz) begin miscompares++; $display("FAIL rnd_haz @%0d: got %b want %b", n, haz_err, m_haz); end
    end
  endtask

  initial begin
    test_reset();
    test_alu_basic();
    test_long_latency();
    test_full_hold();
    test_zero_reg();
    test_waw();
    test_reset_midop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
